// File: rtl/bitrev_scatter.sv
// Bit-reversed to natural order reorder buffer: scatter-writes each frame into one bank of a
// ping-pong RAM and streams full banks out in natural order. Optional last_o via BITREV_SCATTER_LAST_EN.
module bitrev_scatter #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i
`ifdef BITREV_SCATTER_LAST_EN
    ,
    output logic          last_o
`endif
);

    localparam int N = 1 << K;

    logic [DW-1:0] mem [0:2*N-1];

    logic [K-1:0]  wr_cnt;
    logic [K-1:0]  rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic [DW-1:0] data_q;
    logic          valid_q;

    logic          wr_fire;
    logic          rd_fire;
    logic          wr_wrap;
    logic          rd_wrap;

    function automatic logic [K-1:0] bitrev(input logic [K-1:0] x);
        logic [K-1:0] r;
        r = '0;
        for (int b = 0; b < K; b++) begin
            r[b] = x[K-1-b];
        end
        return r;
    endfunction

    assign ready_o = !full_q[wr_bank];
    assign wr_fire = valid_i && ready_o;
    assign rd_fire = full_q[rd_bank] && (!valid_q || ready_i);
    assign wr_wrap = &wr_cnt;
    assign rd_wrap = &rd_cnt;

    // A set needs an empty bank and a clear needs a full one, so both can apply together.
    always_comb begin
        full_d = full_q;
        if (wr_fire && wr_wrap) begin
            full_d[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_wrap) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            full_q  <= 2'b00;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

    // Writes target a non-full bank and reads a full one, so no read-during-write collision.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (rd_fire) begin
                data_q  <= mem[{rd_bank, rd_cnt}];
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef BITREV_SCATTER_LAST_EN
    logic last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else if (rd_fire) begin
            last_q <= rd_wrap;
        end
    end

    assign last_o = last_q && valid_q;
`endif

endmodule

// File: tb/tb_bitrev_scatter.sv
// Self-checking bench for bitrev_scatter (K=3, DW=16) against a frame-level scoreboard model.
module tb_bitrev_scatter;

    localparam int K  = 3;
    localparam int DW = 16;
    localparam int N  = 1 << K;

    logic          clk_i;
    logic          rst_ni;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_i;
`ifdef BITREV_SCATTER_LAST_EN
    logic          last_o;
`endif

    bitrev_scatter #(.K(K), .DW(DW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
`ifdef BITREV_SCATTER_LAST_EN
        ,
        .last_o  (last_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vec  = 0;
    int errs = 0;

    logic [DW-1:0] in_buf[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_last[$];

    function automatic int brev(input int i);
        int r;
        int x;
        r = 0;
        x = i;
        for (int b = 0; b < K; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: inputs were set at the preceding falling edge; outputs are sampled at falling edges.
    task automatic tick();
        logic          acc;
        logic          hs;
        logic          stall;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        logic [DW-1:0] nat[N];
        logic          el;
        logic          held_last;
        acc       = valid_i && ready_o;
        hs        = valid_o && ready_i;
        stall     = valid_o && !ready_i;
        held      = data_o;
        held_last = 1'b0;
`ifdef BITREV_SCATTER_LAST_EN
        held_last = last_o;
`endif
        if (exp_q.size() == 0) begin
            chk("idle_valid", {31'b0, valid_o}, 32'd0);
        end
        if (hs && exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            el = exp_last.pop_front();
            chk("out_data", {16'b0, data_o}, {16'b0, e});
`ifdef BITREV_SCATTER_LAST_EN
            chk("out_last", {31'b0, last_o}, {31'b0, el});
`endif
        end
        if (acc) begin
            in_buf.push_back(data_i);
            if (in_buf.size() == N) begin
                for (int i = 0; i < N; i++) nat[brev(i)] = in_buf[i];
                for (int j = 0; j < N; j++) begin
                    exp_q.push_back(nat[j]);
                    exp_last.push_back(j == N - 1);
                end
                in_buf.delete();
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (stall) begin
            chk("hold_valid", {31'b0, valid_o}, 32'd1);
            chk("hold_data", {16'b0, data_o}, {16'b0, held});
`ifdef BITREV_SCATTER_LAST_EN
            chk("hold_last", {31'b0, last_o}, {31'b0, held_last});
`endif
        end
    endtask

    task automatic feed(input logic [DW-1:0] v);
        logic a;
        int   n;
        n = 0;
        valid_i = 1'b1;
        data_i  = v;
        do begin
            a = ready_o;
            tick();
            n++;
        end while (!a && n < 200);
        chk("feed_accept", {31'b0, a}, 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || valid_o) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int cnt;
        int n;
        int r;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_data", {16'b0, data_o}, 32'd0);
`ifdef BITREV_SCATTER_LAST_EN
        chk("rst_last", {31'b0, last_o}, 32'd0);
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single frame with value = element index
        for (int i = 0; i < N; i++) feed(DW'(brev(i)));
        chk("t1_lat_early", {31'b0, valid_o}, 32'd0);
        tick();
        chk("t1_first_valid", {31'b0, valid_o}, 32'd1);
        chk("t1_first_data", {16'b0, data_o}, 32'd0);
        drain(50);

        // Four back-to-back frames, full rate
        for (int i = 0; i < 4 * N; i++) begin
            chk("t2_ready", {31'b0, ready_o}, 32'd1);
            if (i >= N + 1) chk("t2_valid_cont", {31'b0, valid_o}, 32'd1);
            feed(DW'((i / N) * N + brev(i % N)));
        end
        drain(100);

        // Downstream stalled: both banks fill
        ready_i = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 2 * N && n < 100) begin
            valid_i = 1'b1;
            data_i  = DW'((cnt / N) * N + brev(cnt % N));
            r = int'(ready_o);
            tick();
            if (r != 0) cnt++;
            n++;
        end
        chk("t3_accepts", cnt, 2 * N);
        chk("t3_ready_low", {31'b0, ready_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_ready", {31'b0, ready_o}, 32'd0);
            chk("t3_hold_valid", {31'b0, valid_o}, 32'd1);
            chk("t3_hold_data", {16'b0, data_o}, {16'b0, exp_q[0]});
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int h = 1; h <= N; h++) begin
            tick();
            if (h == N - 2) chk("t3_ready_still_low", {31'b0, ready_o}, 32'd0);
            if (h == N) chk("t3_ready_back", {31'b0, ready_o}, 32'd1);
        end
        drain(100);

        // Random downstream backpressure across three frames
        cnt = 0;
        n = 0;
        while (cnt < 3 * N && n < 400) begin
            valid_i = 1'b1;
            data_i  = DW'($urandom);
            ready_i = $urandom_range(0, 1) != 0;
            r = int'(ready_o);
            tick();
            if (r != 0) cnt++;
            n++;
        end
        chk("t4_accepts", cnt, 3 * N);
        valid_i = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 400) begin
            ready_i = $urandom_range(0, 1) != 0;
            tick();
            n++;
        end
        drain(50);

        // Reset while frame 0 is read out and frame 1 is partial
        for (int i = 0; i < N + 5; i++) feed(DW'($urandom));
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_ready", {31'b0, ready_o}, 32'd1);
        chk("t5_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("t5_rst_data", {16'b0, data_o}, 32'd0);
        in_buf.delete();
        exp_q.delete();
        exp_last.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < N; i++) feed(DW'(brev(i)));
        drain(50);

        // Idle gaps between every input
        for (int i = 0; i < 2 * N; i++) begin
            feed(DW'($urandom));
            valid_i = 1'b0;
            repeat (3) tick();
        end
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
